// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM encoding,
// keyboard command and response bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RELEASE,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_tx_state_e;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_RESEND   = 8'hFE;

    localparam logic [7:0] RSP_ACK = 8'hFA;
    localparam logic [7:0] BREAK   = 8'hF0;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for an open-drain PS/2 line with a
// falling-edge pulse; shared by the transmit and receive paths.
module ps2_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Idle bus is pulled high, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign q_o    = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start, 8 data, odd parity, stop, ACK.
// Optional clock watchdog enabled by defining PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned CNT_W = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);

    ps2_tx_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             dat_low_q, dat_low_d;

    logic clk_s, clk_fall;
    logic dat_s, dat_fall_unused;
    logic frame_bit;
    logic inh_last;
    logic clk_drive, dat_drive;
    logic wd_hit;

    ps2_sync_edge u_clk_sync (
        .clk_i  (CLOCK_50),
        .rst_ni (reset),
        .d_i    (PS2_CLK),
        .q_o    (clk_s),
        .fall_o (clk_fall)
    );

    ps2_sync_edge u_dat_sync (
        .clk_i  (CLOCK_50),
        .rst_ni (reset),
        .d_i    (PS2_DAT),
        .q_o    (dat_s),
        .fall_o (dat_fall_unused)
    );

    always_comb begin
        frame_bit = 1'b1;
        if (bit_q < 4'd8) begin
            frame_bit = shift_q[bit_q[2:0]];
        end else if (bit_q == 4'd8) begin
            frame_bit = par_q;
        end
    end

    assign inh_last = (state_q == ST_INHIBIT) && (cnt_q == INH_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_d     = par_q;
        dat_low_d = dat_low_q;
        done      = 1'b0;
        error     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                dat_low_d = 1'b0;
                if (cmd_valid) begin
                    shift_d = cmd_data;
                    par_d   = odd_parity(cmd_data);
                    cnt_d   = '0;
                    state_d = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (inh_last) begin
                    dat_low_d = 1'b1;
                    state_d   = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                bit_d   = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (clk_fall) begin
                    dat_low_d = ~frame_bit;
                    bit_d     = bit_q + 4'd1;
                    if (bit_q == 4'd9) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                dat_low_d = 1'b0;
                if (clk_fall) begin
                    if (dat_s) begin
                        error   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_s && dat_s) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (wd_hit) begin
            error     = 1'b1;
            dat_low_d = 1'b0;
            state_d   = ST_IDLE;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            dat_low_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            dat_low_q <= dat_low_d;
        end
    end

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_run;

    assign wd_run = (state_q == ST_RELEASE) || (state_q == ST_SEND) ||
                    (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);
    assign wd_hit = wd_run && (wd_q == WD_LAST);

    // Restart on every device clock edge and on each state change.
    always_comb begin
        wd_d = wd_q + 1'b1;
        if (!wd_run || clk_fall || (state_d != state_q)) begin
            wd_d = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign wd_hit         = 1'b0;
`endif

    assign clk_drive = (state_q == ST_INHIBIT);
    assign dat_drive = inh_last ||
                       (dat_low_q && ((state_q == ST_RELEASE) ||
                                      (state_q == ST_SEND)));

    assign PS2_CLK = clk_drive ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_drive ? 1'b0 : 1'bz;

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out
// and compares them with frames built from the byte and its parity.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 6000;
    localparam int TMO = 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready, busy, done, error;
    wire        ps2_clk, ps2_dat;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_err = 0;
    bit prev_pulse = 1'b0;
    logic [7:0] pool [6];

    always #10 clk = ~clk;

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (rst_n),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .PS2_CLK   (ps2_clk),
        .PS2_DAT   (ps2_dat),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Frame as the device sees it: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic p;
        p = ($countones(d) % 2) == 0;
        return {1'b1, p, d, 1'b0};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_is_not_busy", 32'(cmd_ready), 32'(!busy));
            check("done_error_excl", 32'(done & error), 32'd0);
            if (prev_pulse) check("ready_after_pulse", 32'(cmd_ready), 32'd1);
            if (done | error) check("pulse_while_busy", 32'(busy), 32'd1);
            if (!busy && !dev_clk_low && !dev_dat_low) begin
                check("idle_clk_released", 32'(ps2_clk), 32'd1);
                check("idle_dat_released", 32'(ps2_dat), 32'd1);
            end
            if (done) n_done++;
            if (error) n_err++;
            prev_pulse = done | error;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    task automatic dev_frame(input int h, input int nclk, input bit ack,
                             output logic [10:0] samp, output int inh);
        int guard;
        samp  = '0;
        inh   = 0;
        guard = 0;
        while (ps2_clk !== 1'b0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        while (ps2_clk === 1'b0 && inh < 20000) begin
            inh++;
            @(negedge clk);
        end
        for (int k = 0; k < nclk; k++) begin
            repeat (h - 1) @(negedge clk);
            samp[k] = ps2_dat;
            if (k == 10 && ack) begin
                dev_dat_low = 1'b1;
                repeat (2) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (h) @(negedge clk);
            dev_clk_low = 1'b0;
        end
        if (nclk == 11) begin
            repeat (h) @(negedge clk);
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic wait_pulse(input int d0, input int e0);
        for (int i = 0; i < 300; i++) begin
            if (n_done != d0 || n_err != e0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic start_cmd(input logic [7:0] d);
        @(negedge clk);
        check("ready_before_accept", 32'(cmd_ready), 32'd1);
        cmd_data  = d;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic send(input logic [7:0] d, input int h, input bit ack,
                        output logic [10:0] samp);
        int inh, d0, e0;
        start_cmd(d);
        d0 = n_done;
        e0 = n_err;
        dev_frame(h, 11, ack, samp, inh);
        check("inhibit_len", 32'(inh), 32'(INH));
        check("frame_bits", 32'(samp), 32'(model_frame(d)));
        wait_pulse(d0, e0);
        check("done_count", 32'(n_done - d0), ack ? 32'd1 : 32'd0);
        check("error_count", 32'(n_err - e0), ack ? 32'd0 : 32'd1);
        check("ready_after_frame", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #(95000 * 20);
        $display("FAIL global_timeout: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        logic [10:0] samp;
        int inh, d0, e0, t;
        pool[0] = CMD_SET_LEDS;
        pool[1] = CMD_ENABLE;
        pool[2] = CMD_RESET;
        pool[3] = CMD_RESEND;
        pool[4] = RSP_ACK;
        pool[5] = BREAK;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_clk_line", 32'(ps2_clk), 32'd1);
        check("rst_dat_line", 32'(ps2_dat), 32'd1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        send(CMD_SET_LEDS, 10, 1'b1, samp);
        check("ed_frame_literal", 32'(samp), 32'h7DA);
        send(8'h01, 12, 1'b1, samp);
        check("x01_frame_literal", 32'(samp), 32'h402);
        check("x01_parity_bit", 32'(samp[9]), 32'd0);
        send(CMD_RESET, 9, 1'b1, samp);
        check("xff_frame_literal", 32'(samp), 32'h7FE);
        check("xff_parity_bit", 32'(samp[9]), 32'd1);
        send(CMD_ENABLE, 10, 1'b0, samp);
        check("nack_clk_line", 32'(ps2_clk), 32'd1);
        check("nack_dat_line", 32'(ps2_dat), 32'd1);

        // Abort after four device clocks while the host holds DAT low.
        start_cmd(8'h00);
        d0 = n_done;
        e0 = n_err;
        dev_frame(10, 4, 1'b0, samp, inh);
        repeat (3) @(negedge clk);
        check("pre_abort_dat_low", 32'(ps2_dat), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_error", 32'(error), 32'd0);
        check("abort_clk_line", 32'(ps2_clk), 32'd1);
        check("abort_dat_line", 32'(ps2_dat), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("abort_no_pulses", 32'((n_done - d0) + (n_err - e0)), 32'd0);
        repeat (2) @(negedge clk);
        send(CMD_SET_LEDS, 11, 1'b1, samp);

        // cmd_valid held through the frame; data changes after accept.
        @(negedge clk);
        cmd_data  = 8'h3C;
        cmd_valid = 1'b1;
        @(negedge clk);
        check("held_busy", 32'(busy), 32'd1);
        cmd_data = 8'h55;
        d0 = n_done;
        e0 = n_err;
        dev_frame(10, 11, 1'b1, samp, inh);
        check("held_first_frame", 32'(samp), 32'(model_frame(8'h3C)));
        for (int i = 0; i < 300; i++) begin
            if (n_done != d0) break;
            @(negedge clk);
        end
        check("held_first_done", 32'(n_done - d0), 32'd1);
        for (int i = 0; i < 20; i++) begin
            if (busy) break;
            @(negedge clk);
        end
        check("held_reaccept", 32'(busy), 32'd1);
        cmd_valid = 1'b0;
        d0 = n_done;
        dev_frame(10, 11, 1'b1, samp, inh);
        check("held_second_frame", 32'(samp), 32'(model_frame(8'h55)));
        wait_pulse(d0, e0);
        check("held_second_done", 32'(n_done - d0), 32'd1);

        for (int r = 0; r < 2; r++) begin
            logic [7:0] b;
            b = (r == 0) ? 8'($urandom) : pool[$urandom_range(0, 5)];
            send(b, int'($urandom_range(8, 16)), 1'($urandom), samp);
        end

        // Device stops clocking after three bits.
        start_cmd(8'hA5);
        d0 = n_done;
        e0 = n_err;
        dev_frame(10, 3, 1'b0, samp, inh);
`ifdef PS2_HOST_TX_TIMEOUT_EN
        t = 0;
        while (n_err == e0 && t < 1200) begin
            @(negedge clk);
            t++;
        end
        check("timeout_error", 32'(n_err - e0), 32'd1);
        check("timeout_not_early", 32'(t >= TMO - 30), 32'd1);
        check("timeout_not_late", 32'(t <= TMO + 10), 32'd1);
        @(negedge clk);
        check("timeout_idle", 32'(busy), 32'd0);
        check("timeout_clk_line", 32'(ps2_clk), 32'd1);
        check("timeout_dat_line", 32'(ps2_dat), 32'd1);
`else
        t = 0;
        repeat (2 * TMO) @(negedge clk);
        check("stall_still_busy", 32'(busy), 32'd1);
        check("stall_no_error", 32'(n_err - e0), 32'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("stall_reset_idle", 32'(busy), 32'd0);
`endif
        check("stall_no_done", 32'(n_done - d0), 32'(t * 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It sends one command byte to the keyboard (set LEDs 0xED, enable 0xF4, reset 0xFF, ...).
- Performs the full request-to-send sequence: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop, then checks the device ACK bit.
- Shares PS2_CLK/PS2_DAT with the existing PS/2 receive path. Its busy output lets that path ignore bus activity while a transmission is in progress.

Parameters:
- INHIBIT_CYCLES, 6000, CLOCK_50 cycles PS2_CLK is held low before the start bit (120 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000, max CLOCK_50 cycles between device clock falling edges before abort (20 ms); used only with the optional feature.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz
- reset  input  1  asynchronous, active-low reset
- cmd_data  input  8  byte to send; sampled when cmd_valid && cmd_ready
- cmd_valid  input  1  request to send cmd_data
- cmd_ready  output  1  high only in IDLE
- PS2_CLK  inout  1  open-drain: driven 1'b0 or 1'bz only
- PS2_DAT  inout  1  open-drain: driven 1'b0 or 1'bz only
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse: byte sent and device ACK seen
- error  output  1  one-cycle pulse: no ACK (or timeout with feature)

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; both lines released (z).
  - cmd_ready=1, busy=0, done=0, error=0; counters cleared.
- Reset asserted mid-transfer releases both lines immediately. No done/error pulse is issued.
- Input conditioning: PS2_CLK and PS2_DAT each pass through a 2-FF synchronizer.
  - fall = synced clk was 1 last cycle and is 0 now.
  - Data is sampled from the synced value.
- Handshake:
  - Transfer accepted on the cycle cmd_valid && cmd_ready.
  - Latch shift_reg=cmd_data and parity=~^cmd_data.
  - cmd_valid while busy is ignored; it is not queued.
- States:
  - IDLE: lines released. On accept: cnt=0, go INHIBIT.
  - INHIBIT:
    - PS2_CLK driven 0; PS2_DAT released.
    - When cnt==INHIBIT_CYCLES-1: also drive PS2_DAT 0 (start bit), go RELEASE.
  - RELEASE: release PS2_CLK, keep PS2_DAT 0; bit_cnt=0; go SEND.
  - SEND:
    - On each fall, drive PS2_DAT per bit_cnt:
      - 0..7: shift_reg[bit_cnt] (1 = released, 0 = driven low)
      - 8: parity
      - 9: stop, released
    - Then bit_cnt++. After bit_cnt 9 is applied, go ACK.
    - No action between falls.
  - ACK: both lines released. On next fall, sample synced PS2_DAT:
    - 0: go WAIT_IDLE
    - 1: pulse error, go IDLE
  - WAIT_IDLE: when synced PS2_CLK=1 and PS2_DAT=1 in the same cycle, pulse done, go IDLE.
- Latency: cmd_ready returns high the cycle after done/error.
- busy rises the cycle after accept.
- The shared receiver must mask received_data_en while busy=1.
- A device-initiated frame in flight during INHIBIT is overridden by the inhibit (standard PS/2 priority). No special handling.

Optional Feature:
- Macro: PS2_HOST_TX_TIMEOUT_EN.
- Defined:
  - In RELEASE, SEND, ACK and WAIT_IDLE, a watchdog counts cycles since the last fall (or since state entry).
  - On reaching TIMEOUT_CYCLES: release both lines, pulse error, go IDLE.
- Undefined: no watchdog; the FSM waits indefinitely for device clocks; TIMEOUT_CYCLES is unused.

Decomposition:
- Package ps2_pkg holds:
  - FSM state encoding (IDLE, INHIBIT, RELEASE, SEND, ACK, WAIT_IDLE)
  - Command constants: CMD_SET_LEDS 8'hED, CMD_ENABLE 8'hF4, CMD_RESET 8'hFF, CMD_RESEND 8'hFE
  - Response constants: RSP_ACK 8'hFA, BREAK 8'hF0
- One sub-module: ps2_sync_edge (2-FF synchronizer plus falling-edge pulse). The receive path reuses it.

Test Plan:
- Send 0xED; device model ACKs:
  - PS2_CLK low for 6000 cycles, then start bit 0.
  - Data bits 1,0,1,1,0,1,1,1; parity 1; stop released.
  - done pulses once; error stays 0.
- Send 0x01 with ACK -> parity bit 0. Send 0xFF with ACK -> parity bit 1. Both end in done.
- Send 0xF4; device leaves DAT high at the ACK clock -> error pulse, no done, lines released, cmd_ready=1 next cycle.
- Assert reset (low) during SEND at bit_cnt=4 -> lines go z asynchronously, busy=0, no pulses; a new 0xED after reset transfers correctly.
- cmd_valid held high for the whole transfer with data changing to 0x55 -> only the first byte is sent; a second accept occurs in IDLE after done.
- With PS2_HOST_TX_TIMEOUT_EN and TIMEOUT_CYCLES=1000: device stops clocking after 3 bits -> error 1000 cycles after the last fall, lines released. Without the macro, the FSM stays in SEND.
